// File: rtl/req_issuer.sv
// req_issuer: queues command payloads in a small FIFO and presents the head
// entry to a downstream arbiter with a req/gnt handshake. Each request is
// retired on grant or dropped after TIMEOUT cycles, and consecutive requests
// are separated by a GAP-cycle quiet period.
module req_issuer #(
  parameter int WIDTH   = 8,
  parameter int DEPTH   = 4,
  parameter int TIMEOUT = 8,
  parameter int GAP     = 2
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             push,
  input  logic [WIDTH-1:0] push_data,
  input  logic             gnt,
  output logic             req,
  output logic [WIDTH-1:0] data_out,
  output logic             full,
  output logic             empty,
  output logic             done,
  output logic             timeout_err,
  output logic             overflow,
  output logic             spurious_gnt,
  output logic [7:0]       err_cnt
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH) + 1;
  localparam int WW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
  localparam int GW = (GAP > 1) ? $clog2(GAP) : 1;
  localparam logic [WW-1:0] WAIT_LAST = WW'(TIMEOUT - 1);
  localparam logic [GW-1:0] GAP_LAST  = GW'(GAP - 1);

  typedef enum logic [1:0] {S_IDLE, S_REQ, S_GAP} state_t;

  state_t           state;
  logic [WW-1:0]    wcnt;
  logic [GW-1:0]    gcnt;
  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wptr;
  logic [AW-1:0]    rptr;
  logic [CW-1:0]    cnt;
  logic [CW-1:0]    cnt_nxt;
  logic             push_ok;
  logic             pop;

  // Accept/retire decisions and next occupancy for this cycle
  always_comb begin
    push_ok = push && !full;
    pop     = (state == S_REQ) && (gnt || (wcnt == WAIT_LAST));
    cnt_nxt = cnt;
    if (push_ok && !pop) begin
      cnt_nxt = cnt + CW'(1);
    end else if (!push_ok && pop) begin
      cnt_nxt = cnt - CW'(1);
    end
  end

  // Head of queue is presented directly from storage
  always_comb begin
    data_out = mem[rptr];
  end

  // Payload storage; contents need no reset since empty gates their use
  always_ff @(posedge clk) begin
    if (push_ok) begin
      mem[wptr] <= push_data;
    end
  end

  // Pointers, occupancy and registered status flags
  always_ff @(posedge clk) begin
    if (reset) begin
      wptr     <= '0;
      rptr     <= '0;
      cnt      <= '0;
      full     <= 1'b0;
      empty    <= 1'b1;
      overflow <= 1'b0;
    end else begin
      if (push_ok) begin
        wptr <= wptr + AW'(1);
      end
      if (pop) begin
        rptr <= rptr + AW'(1);
      end
      cnt      <= cnt_nxt;
      full     <= (cnt_nxt == CW'(DEPTH));
      empty    <= (cnt_nxt == '0);
      overflow <= push && full;
    end
  end

  // Request handshake FSM with wait/gap counters and event pulses
  always_ff @(posedge clk) begin
    if (reset) begin
      state        <= S_IDLE;
      req          <= 1'b0;
      wcnt         <= '0;
      gcnt         <= '0;
      done         <= 1'b0;
      timeout_err  <= 1'b0;
      spurious_gnt <= 1'b0;
      err_cnt      <= '0;
    end else begin
      done         <= 1'b0;
      timeout_err  <= 1'b0;
      spurious_gnt <= gnt && (state != S_REQ);
      case (state)
        S_IDLE: begin
          if (!empty) begin
            state <= S_REQ;
            req   <= 1'b1;
            wcnt  <= '0;
          end
        end
        S_REQ: begin
          // grant takes precedence over a coincident timeout
          if (gnt) begin
            state <= S_GAP;
            req   <= 1'b0;
            done  <= 1'b1;
            gcnt  <= '0;
          end else if (wcnt == WAIT_LAST) begin
            state       <= S_GAP;
            req         <= 1'b0;
            timeout_err <= 1'b1;
            gcnt        <= '0;
            if (err_cnt != 8'hFF) begin
              err_cnt <= err_cnt + 8'd1;
            end
          end else begin
            wcnt <= wcnt + WW'(1);
          end
        end
        S_GAP: begin
          if (gcnt == GAP_LAST) begin
            state <= S_IDLE;
          end else begin
            gcnt <= gcnt + GW'(1);
          end
        end
        default: begin
          state <= S_IDLE;
          req   <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_req_issuer.sv
// Testbench for req_issuer: table vectors, directed corner sequences and
// randomized traffic, all checked against a request-timeline reference model.
module tb_req_issuer;

  localparam int DEPTHP   = 4;
  localparam int TIMEOUTP = 8;
  localparam int GAPP     = 2;

  logic       clk = 1'b0;
  logic       reset;
  logic       push;
  logic [7:0] push_data;
  logic       gnt;
  logic       req;
  logic [7:0] data_out;
  logic       full;
  logic       empty;
  logic       done;
  logic       timeout_err;
  logic       overflow;
  logic       spurious_gnt;
  logic [7:0] err_cnt;

  req_issuer #(
    .WIDTH   (8),
    .DEPTH   (DEPTHP),
    .TIMEOUT (TIMEOUTP),
    .GAP     (GAPP)
  ) dut (
    .clk          (clk),
    .reset        (reset),
    .push         (push),
    .push_data    (push_data),
    .gnt          (gnt),
    .req          (req),
    .data_out     (data_out),
    .full         (full),
    .empty        (empty),
    .done         (done),
    .timeout_err  (timeout_err),
    .overflow     (overflow),
    .spurious_gnt (spurious_gnt),
    .err_cnt      (err_cnt)
  );

  always #5 clk = ~clk;

  int ncmp = 0;
  int nerr = 0;
  int cyc  = 0;

  // Reference model: queue contents plus how long req has been high or low
  logic [7:0] mq[$];
  bit  m_req;
  int  m_hi;
  int  m_lc;
  int  m_err;
  bit  m_done, m_to, m_ovf, m_sp;

  function automatic void chk(input string nm, input longint act, input longint exp);
    ncmp++;
    if (act != exp) begin
      nerr++;
      $display("FAIL %s at cycle %0d: got %0h, expected %0h", nm, cyc, act, exp);
    end
  endfunction

  function automatic void model_edge(input bit r, input bit p, input logic [7:0] d, input bit g);
    int pre;
    if (r) begin
      mq.delete();
      m_req = 0; m_hi = 0; m_lc = GAPP; m_err = 0;
      m_done = 0; m_to = 0; m_ovf = 0; m_sp = 0;
      return;
    end
    pre    = mq.size();
    m_sp   = g && !m_req;
    m_ovf  = p && (pre == DEPTHP);
    m_done = 0;
    m_to   = 0;
    if (m_req) begin
      if (g) m_done = 1;
      else if (m_hi == TIMEOUTP) m_to = 1;
      if (m_done || m_to) begin
        void'(mq.pop_front());
        m_req = 0;
        m_lc  = 0;
        if (m_to && m_err < 255) m_err++;
      end else begin
        m_hi++;
      end
    end else if (m_lc >= GAPP && pre > 0) begin
      m_req = 1;
      m_hi  = 1;
    end else if (m_lc < GAPP) begin
      m_lc++;
    end
    if (p && pre < DEPTHP) mq.push_back(d);
  endfunction

  function automatic void compare_model();
    chk("req", req, m_req);
    chk("empty", empty, mq.size() == 0);
    chk("full", full, mq.size() == DEPTHP);
    chk("done", done, m_done);
    chk("timeout_err", timeout_err, m_to);
    chk("overflow", overflow, m_ovf);
    chk("spurious_gnt", spurious_gnt, m_sp);
    chk("err_cnt", err_cnt, m_err);
    if (m_req && mq.size() > 0) chk("data_out", data_out, mq[0]);
  endfunction

  task automatic step(input bit r, input bit p, input logic [7:0] d, input bit g);
    reset = r; push = p; push_data = d; gnt = g;
    @(posedge clk);
    model_edge(r, p, d, g);
    #1;
    cyc++;
    compare_model();
  endtask

  typedef struct {
    bit         p;
    logic [7:0] d;
    bit         g;
    bit         e_req;
    bit         e_empty;
    bit         e_done;
    bit         e_spur;
    logic [7:0] e_data;
  } vec_t;

  vec_t tv[10];

  initial begin
    int hi, k, lowrun, ovf_seen;

    tv[0] = '{1'b1, 8'hA5, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 8'h00};
    tv[1] = '{1'b0, 8'h00, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 8'hA5};
    tv[2] = '{1'b0, 8'h00, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 8'hA5};
    tv[3] = '{1'b0, 8'h00, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 8'h00};
    tv[4] = '{1'b0, 8'h00, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 8'h00};
    tv[5] = '{1'b1, 8'h3C, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 8'h00};
    tv[6] = '{1'b0, 8'h00, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 8'h3C};
    tv[7] = '{1'b0, 8'h00, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 8'h00};
    tv[8] = '{1'b0, 8'h00, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 8'h00};
    tv[9] = '{1'b0, 8'h00, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 8'h00};

    // Reset state, with push and gnt held high to show reset priority
    step(1, 1, 8'hFF, 1);
    step(1, 0, 8'h00, 0);
    chk("rst_req", req, 0);
    chk("rst_empty", empty, 1);
    chk("rst_full", full, 0);
    chk("rst_err_cnt", err_cnt, 0);
    chk("rst_pulses", {done, timeout_err, overflow, spurious_gnt}, 0);

    // Single grant, then a spurious grant inside the gap
    for (int i = 0; i < 10; i++) begin
      step(0, tv[i].p, tv[i].d, tv[i].g);
      chk($sformatf("tv%0d_req", i), req, tv[i].e_req);
      chk($sformatf("tv%0d_empty", i), empty, tv[i].e_empty);
      chk($sformatf("tv%0d_done", i), done, tv[i].e_done);
      chk($sformatf("tv%0d_spur", i), spurious_gnt, tv[i].e_spur);
      if (tv[i].e_req) chk($sformatf("tv%0d_data", i), data_out, tv[i].e_data);
    end

    // Timeout with no grant: req high for exactly TIMEOUT cycles
    step(0, 1, 8'h11, 0);
    hi = 0;
    for (int i = 0; i < 40; i++) begin
      step(0, 0, 8'h00, 0);
      if (req) hi++;
      else if (hi > 0) break;
    end
    chk("to_high_cycles", hi, TIMEOUTP);
    chk("to_pulse", timeout_err, 1);
    chk("to_no_done", done, 0);
    chk("to_err_cnt", err_cnt, 1);
    chk("to_empty", empty, 1);
    for (int i = 0; i < GAPP; i++) begin
      step(0, 0, 8'h00, 0);
      chk("to_gap_req", req, 0);
      chk("to_gap_pulse", timeout_err, 0);
    end

    // Grant coincident with the timeout condition: grant wins
    step(0, 1, 8'h22, 0);
    step(0, 0, 8'h00, 0);
    chk("gt_rise", req, 1);
    for (int i = 0; i < TIMEOUTP - 1; i++) begin
      step(0, 0, 8'h00, 0);
      chk("gt_hold", req, 1);
    end
    step(0, 0, 8'h00, 1);
    chk("gt_done", done, 1);
    chk("gt_no_timeout", timeout_err, 0);
    chk("gt_err_cnt", err_cnt, 1);

    // Reset during an active request with three entries queued
    step(0, 0, 8'h00, 0);
    step(0, 0, 8'h00, 0);
    step(0, 1, 8'h31, 0);
    step(0, 1, 8'h32, 0);
    step(0, 1, 8'h33, 0);
    chk("mr_req_before", req, 1);
    step(1, 1, 8'h34, 1);
    chk("mr_req", req, 0);
    chk("mr_empty", empty, 1);
    chk("mr_err_cnt", err_cnt, 0);
    chk("mr_pulses", {done, timeout_err, overflow, spurious_gnt}, 0);

    // Fill past capacity, then drain in order with gaps between grants
    ovf_seen = 0;
    for (int i = 1; i <= 5; i++) begin
      step(0, 1, 8'(i), 0);
      if (i == 4) chk("ov_full", full, 1);
      chk($sformatf("ov_pulse%0d", i), overflow, i == 5);
      ovf_seen += int'(overflow);
    end
    step(0, 0, 8'h00, 0);
    chk("ov_pulse_clear", overflow, 0);
    ovf_seen += int'(overflow);
    chk("ov_pulse_count", ovf_seen, 1);
    k = 0;
    lowrun = 0;
    for (int i = 0; i < 100 && k < 4; i++) begin
      if (req) begin
        chk("ov_order", data_out, k + 1);
        if (k > 0) chk("ov_gap_len", int'(lowrun >= GAPP + 1), 1);
        step(0, 0, 8'h00, 1);
        chk("ov_done", done, 1);
        k++;
        lowrun = 1;
      end else begin
        step(0, 0, 8'h00, 0);
        if (!req) lowrun++;
      end
    end
    chk("ov_done_count", k, 4);
    chk("ov_empty", empty, 1);

    // Continuous timeouts drive the error counter into saturation
    for (int i = 0; i < 3200; i++) step(0, 1, 8'(i), 0);
    chk("sat_err_cnt", err_cnt, 255);

    // Randomized traffic against the reference model
    for (int i = 0; i < 4000; i++) begin
      step($urandom_range(199, 0) == 0,
           $urandom_range(99, 0) < 45,
           8'($urandom),
           $urandom_range(99, 0) < 25);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nerr);
    $finish;
  end

endmodule
